// File: rtl/pipe_flush_stall_controller.sv
// pipe_flush_stall_controller: per-boundary flush/stall generation with deferred jumps, multi-cycle flush and bubbles
module pipe_flush_stall_controller #(
    parameter int NUM_STAGES    = 4,
    parameter int JUMP_STAGE    = 2,
    parameter int FLUSH_CYCLES  = 1,
    parameter int BUBBLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_jump,
    input  logic                  pc_jump_control,
    input  logic                  load_use_hazard,
    input  logic                  bus_stall,
    output logic [NUM_STAGES-1:0] flush_data,
    output logic [NUM_STAGES-1:0] stall_data,
    output logic                  pc_stall,
    output logic                  flush_pending
);
    localparam int MAXC = FLUSH_CYCLES > BUBBLE_CYCLES ? FLUSH_CYCLES : BUBBLE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [NUM_STAGES-1:0] ONES = '1;
    localparam logic [NUM_STAGES-1:0] JMASK = ONES >> (NUM_STAGES - JUMP_STAGE);
    localparam logic [NUM_STAGES-1:0] BMASK = NUM_STAGES'(2);
    localparam logic [NUM_STAGES-1:0] SMASK = NUM_STAGES'(1);
    localparam logic [CW-1:0] FLOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] BLOAD = CW'(BUBBLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PEND, FLUSH, BUBBLE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          j;

    assign j = enable_jump & pc_jump_control;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        flush_data    = '0;
        stall_data    = '0;
        pc_stall      = 1'b0;
        flush_pending = 1'b0;
        if (rst) begin
            flush_data = '1;
        end else if (bus_stall) begin
            stall_data    = '1;
            pc_stall      = 1'b1;
            flush_pending = state == PEND;
            state_n       = j ? PEND : state;
        end else begin
            flush_pending = state == PEND;
            // A pending, new or continuing flush beats any load-use request
            if (state == PEND || state == FLUSH || j) begin
                flush_data = JMASK;
                if (state == FLUSH && !j) begin
                    cnt_n   = cnt - 1'b1;
                    state_n = cnt == CW'(1) ? IDLE : FLUSH;
                end else begin
                    cnt_n   = FLOAD;
                    state_n = FLUSH_CYCLES > 1 ? FLUSH : IDLE;
                end
            end else if (state == BUBBLE || load_use_hazard) begin
                flush_data = BMASK;
                stall_data = SMASK;
                pc_stall   = 1'b1;
                if (state == BUBBLE) begin
                    cnt_n   = cnt - 1'b1;
                    state_n = cnt == CW'(1) ? IDLE : BUBBLE;
                end else begin
                    cnt_n   = BLOAD;
                    state_n = BUBBLE_CYCLES > 1 ? BUBBLE : IDLE;
                end
            end
        end
    end
endmodule
